// File: rtl/bp_be_thread_sched_if.sv
// rtl/bp_be_thread_sched_if.sv - scheduler control/status bundle between backend and thread scheduler
// Ports (scheduler view, modport slave):
//   in : thread_en_i, quantum_i, instret_i, yield_i, npc_w_v_i, npc_i,
//        pc_w_v_i, pc_tid_i, pc_i, pipe_idle_i, redirect_ready_i
//   out: current_thread_id_o, suppress_iss_o, clear_iss_o, redirect_v_o,
//        redirect_pc_o, idle_o
// The master modport is the backend/CSR/FE side driving the scheduler.
interface bp_be_thread_sched_if #(
    parameter int threads_p         = 4,
    parameter int thread_id_width_p = 2,
    parameter int vaddr_width_p     = 39,
    parameter int quantum_width_p   = 16
);
    logic [threads_p-1:0]         thread_en_i;
    logic [quantum_width_p-1:0]   quantum_i;
    logic                         instret_i;
    logic                         yield_i;
    logic                         npc_w_v_i;
    logic [vaddr_width_p-1:0]     npc_i;
    logic                         pc_w_v_i;
    logic [thread_id_width_p-1:0] pc_tid_i;
    logic [vaddr_width_p-1:0]     pc_i;
    logic                         pipe_idle_i;
    logic                         redirect_ready_i;

    logic [thread_id_width_p-1:0] current_thread_id_o;
    logic                         suppress_iss_o;
    logic                         clear_iss_o;
    logic                         redirect_v_o;
    logic [vaddr_width_p-1:0]     redirect_pc_o;
    logic                         idle_o;

    modport master (
        output thread_en_i, quantum_i, instret_i, yield_i, npc_w_v_i, npc_i,
               pc_w_v_i, pc_tid_i, pc_i, pipe_idle_i, redirect_ready_i,
        input  current_thread_id_o, suppress_iss_o, clear_iss_o, redirect_v_o,
               redirect_pc_o, idle_o
    );

    modport slave (
        input  thread_en_i, quantum_i, instret_i, yield_i, npc_w_v_i, npc_i,
               pc_w_v_i, pc_tid_i, pc_i, pipe_idle_i, redirect_ready_i,
        output current_thread_id_o, suppress_iss_o, clear_iss_o, redirect_v_o,
               redirect_pc_o, idle_o
    );
endinterface

// File: rtl/bp_be_thread_sched.sv
// rtl/bp_be_thread_sched.sv - backend hardware-thread scheduler with drain/redirect context switch
// Ports:
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   sched_if   : bp_be_thread_sched_if.slave (thread enables, quantum, retire/yield,
//                commit and CSR PC writes, drain/redirect handshake; current thread,
//                issue suppress/clear, FE redirect, idle status)
module bp_be_thread_sched #(
    parameter int threads_p         = 4,
    parameter int thread_id_width_p = 2,
    parameter int vaddr_width_p     = 39,
    parameter int quantum_width_p   = 16,
    parameter logic [vaddr_width_p-1:0] boot_pc_p = vaddr_width_p'(64'h8000_0000)
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    bp_be_thread_sched_if.slave sched_if
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_SWITCH} state_e;

    state_e                       state_q, state_n;
    logic [thread_id_width_p-1:0] cur_q, cur_n;
    logic [thread_id_width_p-1:0] nxt_q, nxt_n;
    logic                         to_idle_q, to_idle_n;
    logic                         clear_q, clear_n;
    logic [quantum_width_p-1:0]   cnt_q, cnt_n;
    logic [vaddr_width_p-1:0]     pc_table [threads_p];

    logic                         any_en;
    logic [thread_id_width_p-1:0] scan_cur;
    logic [thread_id_width_p-1:0] scan_low;
    logic [thread_id_width_p-1:0] drain_tgt;
    logic [quantum_width_p:0]     cnt_sum;
    logic                         quantum_hit;
    logic                         preempt;

    // First enabled thread after base, wrapping; base itself is tried last.
    // Thread count is a power of two, so the id add wraps naturally.
    function automatic logic [thread_id_width_p-1:0] scan_from(
        input logic [thread_id_width_p-1:0] base,
        input logic [threads_p-1:0]         en
    );
        logic [thread_id_width_p-1:0] idx;
        logic [thread_id_width_p-1:0] res;
        logic                         found;
        res   = base;
        found = 1'b0;
        for (int i = 1; i <= threads_p; i++) begin
            idx = base + thread_id_width_p'(i);
            if (!found && en[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign any_en   = |sched_if.thread_en_i;
    assign scan_cur = scan_from(cur_q, sched_if.thread_en_i);
    // Scanning from the top id yields the lowest-index enabled thread.
    assign scan_low = scan_from({thread_id_width_p{1'b1}}, sched_if.thread_en_i);
    // A thread disabled while draining toward it is replaced at the exit cycle.
    assign drain_tgt = sched_if.thread_en_i[nxt_q] ? nxt_q : scan_cur;

    assign cnt_sum     = {1'b0, cnt_q} + (quantum_width_p+1)'(sched_if.instret_i);
    assign quantum_hit = (sched_if.quantum_i != '0) && (cnt_sum >= {1'b0, sched_if.quantum_i});
    assign preempt     = sched_if.yield_i || quantum_hit || !sched_if.thread_en_i[cur_q];

    always_comb begin
        state_n   = state_q;
        cur_n     = cur_q;
        nxt_n     = nxt_q;
        to_idle_n = to_idle_q;
        cnt_n     = cnt_q;
        clear_n   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_en) begin
                    state_n   = S_SWITCH;
                    nxt_n     = scan_low;
                    cur_n     = scan_low;
                    cnt_n     = '0;
                    clear_n   = 1'b1;
                    to_idle_n = 1'b0;
                end
            end
            S_RUN: begin
                cnt_n = cnt_sum[quantum_width_p] ? '1 : cnt_sum[quantum_width_p-1:0];
                if (preempt) begin
                    if (!any_en) begin
                        state_n   = S_DRAIN;
                        to_idle_n = 1'b1;
                    end else if (scan_cur != cur_q) begin
                        // Also covers a disabled cur: the scan then never lands on it.
                        state_n   = S_DRAIN;
                        nxt_n     = scan_cur;
                        to_idle_n = 1'b0;
                    end else begin
                        // Sole enabled thread: restart its slice without a flush.
                        cnt_n = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (sched_if.pipe_idle_i) begin
                    if (to_idle_q || !any_en) begin
                        state_n   = S_IDLE;
                        to_idle_n = 1'b0;
                    end else begin
                        state_n = S_SWITCH;
                        nxt_n   = drain_tgt;
                        cur_n   = drain_tgt;
                        cnt_n   = '0;
                        clear_n = 1'b1;
                    end
                end
            end
            S_SWITCH: begin
                if (sched_if.redirect_ready_i) begin
                    state_n = S_RUN;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            nxt_q     <= '0;
            to_idle_q <= 1'b0;
            clear_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_n;
            cur_q     <= cur_n;
            nxt_q     <= nxt_n;
            to_idle_q <= to_idle_n;
            clear_q   <= clear_n;
            cnt_q     <= cnt_n;
        end
    end

    // Commit write is issued after the CSR write so it wins an index collision.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < threads_p; i++) begin
                pc_table[i] <= boot_pc_p;
            end
        end else begin
            if (sched_if.pc_w_v_i) begin
                pc_table[sched_if.pc_tid_i] <= sched_if.pc_i;
            end
            if (sched_if.npc_w_v_i && (state_q == S_RUN || state_q == S_DRAIN)) begin
                pc_table[cur_q] <= sched_if.npc_i;
            end
        end
    end

    assign sched_if.current_thread_id_o = cur_q;
    assign sched_if.suppress_iss_o      = (state_q != S_RUN);
    assign sched_if.clear_iss_o         = clear_q;
    assign sched_if.redirect_v_o        = (state_q == S_SWITCH);
    assign sched_if.redirect_pc_o       = pc_table[nxt_q];
    assign sched_if.idle_o              = (state_q == S_IDLE);

endmodule

// File: tb/tb_bp_be_thread_sched.sv
// tb/tb_bp_be_thread_sched.sv - vector-table and scoreboard bench for bp_be_thread_sched
module tb_bp_be_thread_sched;

    localparam logic [38:0] B = 39'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bp_be_thread_sched_if sif ();

    bp_be_thread_sched dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .sched_if  (sif)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  en;
        logic [15:0] q;
        logic        ins;
        logic        yl;
        logic        nv;
        logic [38:0] npc;
        logic        pv;
        logic [1:0]  pt;
        logic [38:0] pc;
        logic        pi;
        logic        rd;
        logic [1:0]  e_tid;
        logic        e_sup;
        logic        e_clr;
        logic        e_rv;
        logic        chk_rpc;
        logic [38:0] e_rpc;
        logic        e_idle;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t e;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t v(
        input logic r, input logic [3:0] en, input logic [15:0] q,
        input logic ins, input logic yl, input logic nv, input logic [38:0] npc,
        input logic pv, input logic [1:0] pt, input logic [38:0] pc,
        input logic pi, input logic rd,
        input logic [1:0] et, input logic es, input logic ec, input logic ev,
        input logic ck, input logic [38:0] ep, input logic ei
    );
        vec_t x;
        x.rst_n = r;   x.en = en;   x.q = q;     x.ins = ins; x.yl = yl;
        x.nv = nv;     x.npc = npc; x.pv = pv;   x.pt = pt;   x.pc = pc;
        x.pi = pi;     x.rd = rd;   x.e_tid = et; x.e_sup = es; x.e_clr = ec;
        x.e_rv = ev;   x.chk_rpc = ck; x.e_rpc = ep; x.e_idle = ei;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst_n                = x.rst_n;
        sif.thread_en_i      = x.en;
        sif.quantum_i        = x.q;
        sif.instret_i        = x.ins;
        sif.yield_i          = x.yl;
        sif.npc_w_v_i        = x.nv;
        sif.npc_i            = x.npc;
        sif.pc_w_v_i         = x.pv;
        sif.pc_tid_i         = x.pt;
        sif.pc_i             = x.pc;
        sif.pipe_idle_i      = x.pi;
        sif.redirect_ready_i = x.rd;
    endtask

    task automatic compare(input vec_t x, input int idx);
        check("tid",      idx, 64'(sif.current_thread_id_o), 64'(x.e_tid));
        check("suppress", idx, 64'(sif.suppress_iss_o),      64'(x.e_sup));
        check("clear",    idx, 64'(sif.clear_iss_o),         64'(x.e_clr));
        check("redir_v",  idx, 64'(sif.redirect_v_o),        64'(x.e_rv));
        check("idle",     idx, 64'(sif.idle_o),              64'(x.e_idle));
        if (x.chk_rpc) check("redir_pc", idx, 64'(sif.redirect_pc_o), 64'(x.e_rpc));
    endtask

    initial begin
        // rst,en,q,ins,yl,nv,npc,pv,pt,pc,pi,rd | tid,sup,clr,rv,chk,rpc,idle
        vecs.push_back(v(1,4'b0001,0,0,0,0,0,0,0,0,0,0, 0,1,1,1,1,B,0));
        vecs.push_back(v(1,4'b0001,0,0,0,0,0,0,0,0,0,0, 0,1,0,1,1,B,0));
        vecs.push_back(v(1,4'b0001,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0101,3,1,0,1,B+39'h4,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0101,3,1,0,1,B+39'h8,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0101,3,1,0,1,B+39'h10,0,0,0,0,0, 0,1,0,0,0,0,0));
        vecs.push_back(v(1,4'b0101,3,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0));
        vecs.push_back(v(1,4'b0101,3,0,0,0,0,0,0,0,1,0, 2,1,1,1,1,B,0));
        vecs.push_back(v(1,4'b0101,3,0,0,0,0,0,0,0,0,1, 2,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0101,3,0,1,0,0,0,0,0,0,0, 2,1,0,0,0,0,0));
        vecs.push_back(v(1,4'b0101,3,0,0,0,0,0,0,0,1,0, 0,1,1,1,1,B+39'h10,0));
        vecs.push_back(v(1,4'b0101,3,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(v(1,4'b0001,2,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0010,0,0,0,1,39'h500,0,0,0,0,0, 0,1,0,0,0,0,0));
        vecs.push_back(v(1,4'b0010,0,0,0,1,39'h600,0,0,0,1,0, 1,1,1,1,1,B,0));
        vecs.push_back(v(1,4'b0010,0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0010,0,0,0,1,39'h100,1,1,39'h200,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0010,0,0,0,0,0,1,3,39'h300,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0000,0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0));
        vecs.push_back(v(1,4'b0000,0,0,0,0,0,0,0,0,1,0, 1,1,0,0,0,0,1));
        vecs.push_back(v(1,4'b0010,0,0,0,1,39'h700,0,0,0,0,0, 1,1,1,1,1,39'h100,0));
        vecs.push_back(v(1,4'b0010,0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b1010,0,0,1,0,0,0,0,0,0,0, 1,1,0,0,0,0,0));
        vecs.push_back(v(1,4'b1010,0,0,0,0,0,0,0,0,1,0, 3,1,1,1,1,39'h300,0));
        vecs.push_back(v(1,4'b1010,0,0,0,1,39'h800,0,0,0,0,0, 3,1,0,1,1,39'h300,0));
        vecs.push_back(v(1,4'b1010,0,0,0,0,0,0,0,0,0,0, 3,1,0,1,1,39'h300,0));
        vecs.push_back(v(1,4'b1010,0,0,0,0,0,0,0,0,0,0, 3,1,0,1,1,39'h300,0));
        vecs.push_back(v(1,4'b1010,0,0,0,0,0,1,3,39'h340,0,0, 3,1,0,1,1,39'h340,0));
        vecs.push_back(v(1,4'b1010,0,0,0,0,0,0,0,0,0,1, 3,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0010,0,0,1,0,0,0,0,0,0,0, 3,1,0,0,0,0,0));
        vecs.push_back(v(1,4'b0010,0,0,0,0,0,0,0,0,1,0, 1,1,1,1,1,39'h100,0));
        vecs.push_back(v(1,4'b0010,0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0011,0,0,1,0,0,0,0,0,0,0, 1,1,0,0,0,0,0));
        vecs.push_back(v(1,4'b0011,0,0,0,0,0,0,0,0,1,0, 0,1,1,1,1,39'h600,0));
        vecs.push_back(v(0,4'b0011,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,B,1));
        vecs.push_back(v(1,4'b0001,0,0,0,0,0,0,0,0,0,0, 0,1,1,1,1,B,0));
        vecs.push_back(v(1,4'b0001,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
        vecs.push_back(v(1,4'b0011,0,0,1,0,0,0,0,0,0,0, 0,1,0,0,0,0,0));
        vecs.push_back(v(0,4'b0011,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,B,1));
        vecs.push_back(v(1,4'b0000,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,B,1));

        drive(v(0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,B,1));
        repeat (2) @(posedge clk);
        #1;
        compare(v(0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,B,1), -1);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            sb.push_back(vecs[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compare(e, k);
        end

        // Reset must act without waiting for a clock edge.
        drive(v(1,4'b0010,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(v(1,4'b0010,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        check("async_pre_tid", 100, 64'(sif.current_thread_id_o), 64'd1);
        drive(v(1,4'b0011,0,0,1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        sif.yield_i = 1'b0;
        check("async_pre_sup", 101, 64'(sif.suppress_iss_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        compare(v(0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,B,1), 102);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_be_thread_sched.md
Name: bp_be_thread_sched

Overview:
- Backend hardware-thread scheduler. Drives the current thread ID into the scheduler/regfile datapath and time-multiplexes issue among enabled threads.
- Preempts the running thread on quantum expiry, yield or disable. It suppresses issue, waits for the pipeline to drain, then redirects fetch to the next thread's saved PC.
- Keeps a per-thread resume-PC table, updated from commit and from CSR writes.

Parameters:
- threads_p, 4, number of hardware threads (power of 2, >=2).
- thread_id_width_p, 2, log2(threads_p).
- vaddr_width_p, 39, PC width.
- quantum_width_p, 16, instret quantum counter width.
- boot_pc_p, 0x80000000, reset value of every PC table entry.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- thread_en_i  in  threads_p  per-thread enable mask (CSR).
- quantum_i  in  quantum_width_p  retired instructions per timeslice; 0 disables time preemption.
- instret_i  in  1  an instruction of the current thread retired this cycle.
- yield_i  in  1  current thread yields (wfi/explicit); single-cycle pulse.
- npc_w_v_i  in  1  commit next-PC valid for current thread.
- npc_i  in  vaddr_width_p  commit next-PC.
- pc_w_v_i  in  1  CSR write of a thread's resume PC.
- pc_tid_i  in  thread_id_width_p  target thread of the CSR write.
- pc_i  in  vaddr_width_p  CSR PC data.
- pipe_idle_i  in  1  backend drained: no in-flight instructions, no late writebacks.
- redirect_ready_i  in  1  FE accepts redirect.
- current_thread_id_o  out  thread_id_width_p  thread owning issue and regfile ports.
- suppress_iss_o  out  1  block issue-queue enqueue/issue.
- clear_iss_o  out  1  single-cycle issue-queue flush.
- redirect_v_o  out  1  redirect request to FE.
- redirect_pc_o  out  vaddr_width_p  resume PC of the incoming thread.
- idle_o  out  1  no enabled thread.

Behaviour:
- States: IDLE, RUN, DRAIN, SWITCH.
- Reset: state IDLE, cur=0, counter=0, pc table all boot_pc_p. Outputs: current_thread_id_o=0, suppress_iss_o=1, clear_iss_o=0, redirect_v_o=0, redirect_pc_o=boot_pc_p, idle_o=1.
- next = first enabled thread scanning cur+1, cur+2, ... wrapping mod threads_p. cur itself is checked last.
- IDLE:
  - suppress_iss_o=1, idle_o=1.
  - If |thread_en_i: nxt <= lowest-index enabled thread, go SWITCH.
- RUN:
  - suppress_iss_o=0.
  - counter += instret_i; saturates at all-ones.
  - Preempt when any of: yield_i; or quantum_i!=0 and counter+instret_i >= quantum_i; or !thread_en_i[cur].
  - On preempt, if next != cur, or cur is disabled: go DRAIN, latch nxt=next. If no thread is enabled, latch "to-idle".
  - On preempt when cur is the only enabled thread: stay RUN, counter <= 0, no flush.
- DRAIN:
  - suppress_iss_o=1; the counter holds.
  - When pipe_idle_i is high, go SWITCH, or go IDLE if to-idle is set. The exit is taken in the same cycle pipe_idle_i is seen.
  - If thread_en_i[nxt] drops during DRAIN, nxt is re-evaluated on the exit cycle.
- SWITCH:
  - Entry cycle: cur <= nxt, clear_iss_o=1 (one cycle), counter <= 0.
  - redirect_v_o=1 with redirect_pc_o=pc_table[nxt]; suppress_iss_o=1.
  - Hold until redirect_ready_i, then go RUN next cycle. redirect_v_o/pc stay stable until accepted.
- current_thread_id_o is registered and changes only on the SWITCH entry edge.
- PC table:
  - npc_w_v_i writes pc_table[cur] in RUN and DRAIN; it is ignored in IDLE and SWITCH.
  - pc_w_v_i writes pc_table[pc_tid_i] in any state.
  - Same-cycle same-index collision: commit write wins.
  - A CSR write to nxt while in SWITCH is visible on redirect_pc_o the next cycle.
- Simultaneous yield_i and thread disable: one preemption only.
- Reset asserted mid-DRAIN or mid-SWITCH: immediate return to reset values, no redirect.

Test Plan:
- Reset → thread_en=4'b0001 → IDLE, then SWITCH with redirect_pc_o=0x80000000 and clear pulse; after redirect_ready_i, RUN with tid=0 and suppress=0.
- en=4'b0101, quantum=3, retire 3 instrs (last npc=0x80000010), pipe_idle_i after 2 cycles → DRAIN for exactly 2 cycles. Then tid=2 with redirect 0x80000000; return to tid 0 later redirects to 0x80000010.
- en=4'b0001, quantum=2, 5 retires → never leaves RUN, clear_iss_o never pulses, counter resets at each expiry.
- Running tid 1, clear thread_en[1] with en=4'b0010→4'b0000 → DRAIN, then IDLE with idle_o=1 and suppress=1.
- Same cycle: commit npc_w_v_i (tid 1, 0x100) and pc_w_v_i(tid 1, 0x200) → table[1]=0x100; pc_w_v_i(tid 3, 0x300) alone → later switch to 3 redirects 0x300.
- SWITCH with redirect_ready_i low for 4 cycles → redirect_v_o and pc stable, clear pulses once; reset_n_i asserted during DRAIN → all outputs at reset values.
